// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared constants and helpers for the gpio_bank I/O bank.
package gpio_bank_pkg;

  // Direction encoding of DIR / dir_q bits.
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Default parameter values for the bank and its synchroniser.
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;

  // Ceiling log2, never below 1 so a counter is always at least one bit wide.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/gpio_bank_sync.sv
// gpio_bank_sync: single-bit pad-to-core synchroniser, optionally followed by
// a debounce filter. The filter exists only when GPIO_BANK_DEBOUNCE_EN is defined.
module gpio_bank_sync
  import gpio_bank_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef GPIO_BANK_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // Shift the raw pad value through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int               CNT_W    = clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Count consecutive cycles where s disagrees with the filtered value and adopt s after DEB_CYCLES of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (s == filt_q) begin
      cnt_q <= '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) filt_q <= s;
    end
  end

  assign q = filt_q;
`else
  assign q = s;
`endif

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: registered bank of WIDTH general purpose I/Os with config-done and
// isolation gating, input synchronisation, sticky edge flags and a masked IRQ.
// Optional debounce on the input path: define GPIO_BANK_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             CONFIG_DONE,
  input  logic             IO_ISOL_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] DIR,
  output logic [WIDTH-1:0] Y,
  inout  wire  [WIDTH-1:0] PAD,
  input  logic [WIDTH-1:0] EVT_MASK,
  input  logic [WIDTH-1:0] EVT_CLR,
  output logic [WIDTH-1:0] EVT,
  output logic             IRQ
);

  // Reject parameter values the bank cannot be built with.
  if (WIDTH < 1 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_params
    $error("gpio_bank: illegal parameter value");
  end

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] oe_d;
  logic             cfg_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] y_prev;
  logic [WIDTH-1:0] evt_q;

  // A channel drives its pad only when configured, not isolated and set to output.
  always_comb begin
    // NOTE: the default comes first so every path assigns oe_d and no latch is inferred.
    oe_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      oe_d[i] = CONFIG_DONE && IO_ISOL_N && (DIR[i] == DIR_OUT);
    end
  end

  // Register fabric data, direction, config-done and the output enables.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      a_q   <= '0;
      dir_q <= {WIDTH{DIR_IN}};
      oe_q  <= '0;
      cfg_q <= 1'b0;
    end else begin
      a_q   <= A;
      dir_q <= DIR;
      oe_q  <= oe_d;
      cfg_q <= CONFIG_DONE;
    end
  end

  // Per-channel pad driver and input synchroniser.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    assign PAD[i] = oe_q[i] ? a_q[i] : 1'bz;

    gpio_bank_sync #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_BANK_DEBOUNCE_EN
      ,
      .DEB_CYCLES (DEB_CYCLES)
`endif
    ) u_sync (
      .clk  (CK),
      .rst_n(RSTN),
      .d    (PAD[i]),
      .q    (s[i])
    );
  end

  // Input channels (dir_q = DIR_IN) pass synchronised pad data once configured; blocked bits read 0.
  assign Y = s & dir_q & {WIDTH{cfg_q}};

  // Sticky edge flags: any change of Y sets the flag, and a set beats a same-cycle clear.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      y_prev <= '0;
      evt_q  <= '0;
    end else begin
      y_prev <= Y;
      evt_q  <= (evt_q & ~EVT_CLR) | (Y ^ y_prev);
    end
  end

  assign EVT = evt_q;
  assign IRQ = |(evt_q & EVT_MASK);

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed vector table, debounce sequences (with GPIO_BANK_DEBOUNCE_EN)
// and randomized stimulus checked against a cycle-level reference model.
module tb_gpio_bank;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic         ck = 1'b0;
  logic         rstn;
  logic         cfg;
  logic         isol_n;
  logic [W-1:0] a;
  logic [W-1:0] dir;
  logic [W-1:0] mask;
  logic [W-1:0] clr;
  logic [W-1:0] drv_en;
  logic [W-1:0] drv_val;
  logic [W-1:0] y;
  logic [W-1:0] evt;
  logic         irq;
  wire  [W-1:0] pad;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_bank #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB)
  ) dut (
    .CK         (ck),
    .RSTN       (rstn),
    .CONFIG_DONE(cfg),
    .IO_ISOL_N  (isol_n),
    .A          (a),
    .DIR        (dir),
    .Y          (y),
    .PAD        (pad),
    .EVT_MASK   (mask),
    .EVT_CLR    (clr),
    .EVT        (evt),
    .IRQ        (irq)
  );

  // External pad drivers; an undriven pad is pulled high so high-Z is observable.
  for (genvar i = 0; i < W; i++) begin : g_pad
    assign pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
    pullup pu (pad[i]);
  end

  always #5 ck = ~ck;

  // ---------------- reference model ----------------
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_dir   = '1;
  logic [W-1:0] m_oe    = '0;
  logic         m_cfg   = 1'b0;
  logic [W-1:0] m_hist [SYNC];   // pad samples, [0] newest
  logic [W-1:0] m_yprev = '0;
  logic [W-1:0] m_evt   = '0;
`ifdef GPIO_BANK_DEBOUNCE_EN
  logic [W-1:0] m_filt  = '0;
  int           m_run [W];
`endif

  // Value a pad settles to given who is driving it.
  function automatic logic [W-1:0] resolve(input logic [W-1:0] oe, input logic [W-1:0] av,
                                           input logic [W-1:0] en, input logic [W-1:0] v);
    return (oe & av) | (~oe & en & v) | (~oe & ~en);
  endfunction

  function automatic logic [W-1:0] model_y();
`ifdef GPIO_BANK_DEBOUNCE_EN
    return m_filt & m_dir & {W{m_cfg}};
`else
    return m_hist[SYNC-1] & m_dir & {W{m_cfg}};
`endif
  endfunction

  task automatic model_edge(input logic [W-1:0] smp);
    logic [W-1:0] y_now;
    logic [W-1:0] s_old;
    if (!rstn) begin
      m_a = '0; m_dir = '1; m_oe = '0; m_cfg = 1'b0;
      for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
      m_yprev = '0; m_evt = '0;
`ifdef GPIO_BANK_DEBOUNCE_EN
      m_filt = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
`endif
    end else begin
      y_now   = model_y();
      s_old   = m_hist[SYNC-1];
      m_evt   = (m_evt & ~clr) | (y_now ^ m_yprev);
      m_yprev = y_now;
`ifdef GPIO_BANK_DEBOUNCE_EN
      for (int i = 0; i < W; i++) begin
        if (s_old[i] == m_filt[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin
            m_filt[i] = s_old[i];
            m_run[i]  = 0;
          end
        end
      end
`endif
      for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = smp;
      m_a   = a;
      m_dir = dir;
      m_cfg = cfg;
      m_oe  = (cfg && isol_n) ? ~dir : '0;
    end
  endtask

  // One clock: model sees the pre-edge pad, outputs are sampled on the falling edge.
  task automatic tick();
    logic [W-1:0] smp;
    smp = resolve(m_oe, m_a, drv_en, drv_val);
    @(posedge ck);
    model_edge(smp);
    @(negedge ck);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rstn, cfg, isol_n;
    logic [7:0] dir, a, drv_en, drv_val, mask, clr;
    logic [7:0] y, pad, evt;
    logic       irq;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  initial begin
    logic [W-1:0] oe_next;

    rstn = 1'b0; cfg = 1'b1; isol_n = 1'b1; dir = '0; a = '0;
    mask = '0; clr = '0; drv_en = '0; drv_val = '0;
    for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
`ifdef GPIO_BANK_DEBOUNCE_EN
    for (int i = 0; i < W; i++) m_run[i] = 0;
`endif

`ifndef GPIO_BANK_DEBOUNCE_EN
    // Fields: rstn cfg isol dir a drv_en drv mask clr | y pad evt irq
    vecs[0]  = '{0,1,1,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hFF,8'h00,0}; // reset: pads Z
    vecs[1]  = '{0,1,1,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hFF,8'h00,0};
    vecs[2]  = '{1,1,1,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,0}; // driving resumes
    vecs[3]  = '{1,1,1,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hFF,8'h00,0};
    vecs[4]  = '{1,1,1,8'h00,8'hF0,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hF0,8'h00,0};
    vecs[5]  = '{1,1,1,8'h00,8'hF0,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hF0,8'h00,0};
    vecs[6]  = '{1,1,1,8'h0F,8'hA5,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hAF,8'h00,0}; // low nibble released
    vecs[7]  = '{1,1,1,8'h0F,8'hA5,8'h0F,8'h06,8'h00,8'h00, 8'h00,8'hA6,8'h00,0};
    vecs[8]  = '{1,1,1,8'h0F,8'hA5,8'h0F,8'h06,8'h00,8'h00, 8'h06,8'hA6,8'h00,0}; // 2-cycle pad->Y
    vecs[9]  = '{1,1,1,8'h0F,8'hA5,8'h0F,8'h06,8'h00,8'h00, 8'h06,8'hA6,8'h06,0}; // EVT[2:1]
    vecs[10] = '{1,1,0,8'h00,8'hA5,8'h0F,8'h06,8'h00,8'h00, 8'h00,8'hF6,8'h06,0}; // isolation: all Z
    vecs[11] = '{1,1,0,8'h00,8'hA5,8'hFF,8'h3C,8'h00,8'h00, 8'h00,8'h3C,8'h06,0};
    vecs[12] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h00,8'h00, 8'h3C,8'h3C,8'h06,0};
    vecs[13] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h00,8'h00, 8'h3C,8'h3C,8'h3E,0};
    vecs[14] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3D,8'h01,8'h00, 8'h3C,8'h3D,8'h3E,0};
    vecs[15] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3D,8'h01,8'h00, 8'h3D,8'h3D,8'h3E,0};
    vecs[16] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h01,8'h00, 8'h3D,8'h3C,8'h3F,1}; // masked IRQ
    vecs[17] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h01,8'h00, 8'h3C,8'h3C,8'h3F,1};
    vecs[18] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h01,8'h01, 8'h3C,8'h3C,8'h3F,1}; // set beats clear
    vecs[19] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h01,8'h01, 8'h3C,8'h3C,8'h3E,0}; // plain clear
    vecs[20] = '{1,1,0,8'hFF,8'hA5,8'hFF,8'h3C,8'h01,8'hFF, 8'h3C,8'h3C,8'h00,0};
    vecs[21] = '{1,1,1,8'hFF,8'hA5,8'hFF,8'hFF,8'h00,8'h00, 8'h3C,8'hFF,8'h00,0};
    vecs[22] = '{1,1,1,8'hFF,8'hA5,8'hFF,8'hFF,8'h00,8'h00, 8'hFF,8'hFF,8'h00,0};
    vecs[23] = '{1,1,1,8'hFF,8'hA5,8'hFF,8'hFF,8'h00,8'h00, 8'hFF,8'hFF,8'hC3,0};
    vecs[24] = '{1,1,1,8'hFF,8'hA5,8'hFF,8'hFF,8'h00,8'hFF, 8'hFF,8'hFF,8'h00,0};
    vecs[25] = '{1,0,1,8'hFF,8'hA5,8'hFF,8'hFF,8'hFF,8'h00, 8'h00,8'hFF,8'h00,0}; // config drops
    vecs[26] = '{1,0,1,8'hFF,8'hA5,8'hFF,8'hFF,8'hFF,8'h00, 8'h00,8'hFF,8'hFF,1}; // Y fall -> EVT
    vecs[27] = '{0,1,1,8'h00,8'h00,8'h00,8'h00,8'hFF,8'h00, 8'h00,8'hFF,8'h00,0}; // reset mid-run
    vecs[28] = '{1,1,1,8'h00,8'h55,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h55,8'h00,0};
    vecs[29] = '{1,0,1,8'h00,8'h55,8'h00,8'h00,8'h00,8'h00, 8'h00,8'hFF,8'h00,0}; // pads release

    for (int k = 0; k < NV; k++) begin
      rstn = vecs[k].rstn; cfg = vecs[k].cfg; isol_n = vecs[k].isol_n;
      dir = vecs[k].dir; a = vecs[k].a; drv_en = vecs[k].drv_en; drv_val = vecs[k].drv_val;
      mask = vecs[k].mask; clr = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_y", k),   y,   vecs[k].y);
      check($sformatf("vec%0d_pad", k), pad, vecs[k].pad);
      check($sformatf("vec%0d_evt", k), evt, vecs[k].evt);
      check($sformatf("vec%0d_irq", k), irq, vecs[k].irq);
    end
`else
    // Debounce: reset, then hold every channel as input with pads driven low.
    repeat (2) tick();
    check("deb_reset_y", y, 8'h00);
    rstn = 1'b1; dir = '1; drv_en = '1; drv_val = '0;
    repeat (10) tick();
    check("deb_settle_y", y, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      drv_val = (k <= 3) ? 8'h01 : 8'h00;
      tick();
      check($sformatf("deb_short_%0d", k), y[0], 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      drv_val = (k <= 5) ? 8'h01 : 8'h00;
      tick();
      check($sformatf("deb_long_%0d", k), y[0], (k >= SYNC + DEB) ? 1'b1 : 1'b0);
    end
`endif

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 400; n++) begin
      rstn    = ($urandom_range(0, 39) != 0);
      cfg     = ($urandom_range(0, 9) != 0);
      isol_n  = ($urandom_range(0, 7) != 0);
      dir     = W'($urandom) | W'($urandom);
      a       = W'($urandom);
      mask    = W'($urandom);
      clr     = W'($urandom) & W'($urandom) & W'($urandom);
      oe_next = (rstn && cfg && isol_n) ? ~dir : '0;
      drv_en  = W'($urandom) & ~m_oe & ~oe_next;
      if ($urandom_range(0, 5) == 0) drv_val = W'($urandom);
      tick();
      check($sformatf("rand%0d_y", n),   y,   model_y());
      check($sformatf("rand%0d_pad", n), pad, resolve(m_oe, m_a, drv_en, drv_val));
      check($sformatf("rand%0d_evt", n), evt, m_evt);
      check($sformatf("rand%0d_irq", n), irq, |(m_evt & mask));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
